// File: rtl/read_d_streamer.sv
`default_nettype none
// ============================================================================
// read_d_streamer: walks the read/D(i) ROM from last_idx down to 0 and streams
// {idx, read, d, last} beats through a small FIFO. Macro READ_D_MONOTONIC_CHECK_EN
// adds the sticky o_d_err flag.      Revision: 1.0
// ============================================================================
module read_d_streamer #(
  parameter int ADDR_W = 8,
  parameter int D_W    = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_last_idx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rom_ce,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [1:0]        i_rom_read_i,
  input  logic [D_W-1:0]    i_rom_d_i,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_idx,
  output logic [1:0]        o_out_read,
  output logic [D_W-1:0]    o_out_d,
  output logic              o_out_last
`ifdef READ_D_MONOTONIC_CHECK_EN
  ,
  output logic              o_d_err
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + 2 + D_W + 1;
  localparam logic [ADDR_W-1:0] c_IDX_NONE = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_idx;
  logic               r_done;
  logic [ENT_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_start_ok;
  logic [ENT_W-1:0]   w_wdata;
  logic [ENT_W-1:0]   w_head;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = !w_empty && i_out_ready;
  assign w_push     = (r_state == S_FETCH) && (!w_full || w_pop);
  assign w_start_ok = i_start && (r_state == S_IDLE);
  assign w_wdata    = {r_idx, i_rom_read_i, i_rom_d_i, (r_idx == '0)};
  assign w_head     = r_mem[r_rptr];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_last_idx == c_IDX_NONE) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_push && (r_idx == '0)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      // Look ahead by one pop so done lands the cycle after the last beat leaves.
      S_DRAIN: begin
        if (w_empty || ((r_count == CNT_W'(1)) && w_pop)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_DONE);
      if (w_start_ok) begin
        r_idx <= i_last_idx;
      end else if (w_push) begin
        r_idx <= r_idx - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_wdata;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef READ_D_MONOTONIC_CHECK_EN
  logic [D_W-1:0] r_prev_d;
  logic           r_have_prev;
  logic           r_d_err;

  // D(i) must not grow as i descends; the first push of a run has no predecessor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_d    <= '0;
      r_have_prev <= 1'b0;
      r_d_err     <= 1'b0;
    end else if (w_start_ok) begin
      r_have_prev <= 1'b0;
      r_d_err     <= 1'b0;
    end else if (w_push) begin
      if (r_have_prev && (i_rom_d_i > r_prev_d)) begin
        r_d_err <= 1'b1;
      end
      r_prev_d    <= i_rom_d_i;
      r_have_prev <= 1'b1;
    end
  end

  assign o_d_err = r_d_err;
`endif

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_rom_ce    = w_push;
  assign o_rom_addr  = w_push ? r_idx : c_IDX_NONE;
  assign o_out_valid = !w_empty;
  assign o_out_idx   = w_head[ENT_W-1 -: ADDR_W];
  assign o_out_read  = w_head[D_W+2 -: 2];
  assign o_out_d     = w_head[D_W:1];
  assign o_out_last  = w_head[0] && !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_read_d_streamer.sv
`default_nettype none
// Self-checking bench for read_d_streamer: ROM model, expected-beat queue,
// randomized ready patterns.
module tb_read_d_streamer;
  localparam int ADDR_W = 8;
  localparam int D_W    = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic [ADDR_W-1:0] i_last_idx = '0;
  logic o_busy, o_done, o_rom_ce, o_out_valid, o_out_last;
  logic [ADDR_W-1:0] o_rom_addr, o_out_idx;
  logic [1:0] i_rom_read_i, o_out_read;
  logic [D_W-1:0] i_rom_d_i, o_out_d;
  logic i_out_ready = 1'b0;
`ifdef READ_D_MONOTONIC_CHECK_EN
  logic o_d_err;
`endif

  logic [1:0]     rom_rd [256];
  logic [D_W-1:0] rom_dv [256];
  assign i_rom_read_i = rom_rd[o_rom_addr];
  assign i_rom_d_i    = rom_dv[o_rom_addr];

  read_d_streamer #(.ADDR_W(ADDR_W), .D_W(D_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_last_idx(i_last_idx),
    .o_busy(o_busy), .o_done(o_done), .o_rom_ce(o_rom_ce), .o_rom_addr(o_rom_addr),
    .i_rom_read_i(i_rom_read_i), .i_rom_d_i(i_rom_d_i),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_idx(o_out_idx),
    .o_out_read(o_out_read), .o_out_d(o_out_d), .o_out_last(o_out_last)
`ifdef READ_D_MONOTONIC_CHECK_EN
    , .o_d_err(o_d_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int obs_idx[$], obs_rd[$], obs_d[$], obs_last[$];
  int exp_idx[$], exp_rd[$], exp_d[$], exp_last[$];
  logic exp_err;
  int first_valid_cyc, done_cyc, stall_err, ce_cnt, ce_bad, ce_hold, timed_out;

  // Expected beat order: every index from last down to 0, straight from the ROM.
  task automatic build_model(input int last);
    exp_idx.delete(); exp_rd.delete(); exp_d.delete(); exp_last.delete();
    exp_err = 1'b0;
    for (int i = last; i >= 0; i--) begin
      exp_idx.push_back(i);
      exp_rd.push_back(int'(rom_rd[i]));
      exp_d.push_back(int'(rom_dv[i]));
      exp_last.push_back(i == 0 ? 1 : 0);
      if (i < last && rom_dv[i] > rom_dv[i+1]) exp_err = 1'b1;
    end
  endtask

  function automatic int beat_errors();
    int n = 0;
    if (obs_idx.size() != exp_idx.size()) n++;
    for (int i = 0; i < obs_idx.size() && i < exp_idx.size(); i++) begin
      if (obs_idx[i] != exp_idx[i] || obs_rd[i] != exp_rd[i] ||
          obs_d[i] != exp_d[i] || obs_last[i] != exp_last[i]) n++;
    end
    return n;
  endfunction

  task automatic fill_rom_random();
    for (int i = 0; i < 256; i++) begin
      rom_rd[i] = 2'($urandom_range(0, 3));
      rom_dv[i] = D_W'($urandom_range(0, 255));
    end
  endtask

  // mode 0: ready high; mode 1: random ready plus a stray start; mode 2: ready low until cycle 'hold'.
  task automatic drive_run(input logic [7:0] last, input int mode, input int hold);
    logic prev_stall;
    logic [19:0] prev_pl, pl;
    int cyc;
    obs_idx.delete(); obs_rd.delete(); obs_d.delete(); obs_last.delete();
    first_valid_cyc = -1; done_cyc = -1; stall_err = 0;
    ce_cnt = 0; ce_bad = 0; ce_hold = 0; timed_out = 0;
    prev_stall = 1'b0; prev_pl = '0; cyc = 0;
    i_last_idx = last;
    i_start = 1'b1;
    i_out_ready = (mode == 0);
    while (done_cyc < 0 && timed_out == 0) begin
      @(negedge clk);
      cyc++;
      i_start = (mode == 1 && cyc == 5);
      if (i_start) i_last_idx = 8'd3;
      case (mode)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = 1'($urandom_range(0, 1));
        default: i_out_ready = (cyc >= hold);
      endcase
      #1;
      pl = {o_out_valid, o_out_idx, o_out_read, o_out_d, o_out_last};
      if (o_rom_ce) begin
        ce_cnt++;
        if (o_rom_addr == 8'hff) ce_bad++;
        if (cyc < hold) ce_hold++;
      end
      if (prev_stall && pl !== prev_pl) stall_err++;
      if (o_out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_out_valid && i_out_ready) begin
        obs_idx.push_back(int'(o_out_idx));
        obs_rd.push_back(int'(o_out_read));
        obs_d.push_back(int'(o_out_d));
        obs_last.push_back(int'(o_out_last));
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_pl = pl;
      if (o_done) done_cyc = cyc;
      if (cyc >= 3000) timed_out = 1;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", o_done); end
    checks++; if (o_rom_ce !== 1'b0) begin failures++; $display("FAIL reset_rom_ce got=%b want=0", o_rom_ce); end
    checks++; if (o_rom_addr !== 8'hff) begin failures++; $display("FAIL reset_rom_addr got=%h want=ff", o_rom_addr); end
    checks++; if (o_out_valid !== 1'b0 || o_out_last !== 1'b0) begin
      failures++; $display("FAIL reset_out got valid=%b last=%b want 0/0", o_out_valid, o_out_last);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    rom_rd[0] = 2'b00; rom_dv[0] = 8'd0;
    rom_rd[1] = 2'b01; rom_dv[1] = 8'd1;
    rom_rd[2] = 2'b11; rom_dv[2] = 8'd1;
    build_model(2);
    drive_run(8'd2, 0, 0);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL basic_timeout got=%0d want=0", timed_out); end
    checks++; if (beat_errors() != 0) begin failures++; $display("FAIL basic_beats bad=%0d want=0 n=%0d", beat_errors(), obs_idx.size()); end
    checks++; if (first_valid_cyc != 2) begin failures++; $display("FAIL basic_first_valid got=%0d want=2", first_valid_cyc); end
    checks++; if (done_cyc != 6) begin failures++; $display("FAIL basic_done_cycle got=%0d want=6", done_cyc); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b want=0", o_busy); end
    @(negedge clk); #1;
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b want=0", o_done); end
`ifdef READ_D_MONOTONIC_CHECK_EN
    checks++; if (o_d_err !== exp_err) begin failures++; $display("FAIL basic_d_err got=%b want=%b", o_d_err, exp_err); end
`endif
  endtask

  task automatic test_empty();
    drive_run(8'hff, 0, 0);
    checks++; if (ce_cnt != 0) begin failures++; $display("FAIL empty_rom_ce got=%0d want=0", ce_cnt); end
    checks++; if (first_valid_cyc != -1) begin failures++; $display("FAIL empty_valid got=%0d want=-1", first_valid_cyc); end
    checks++; if (done_cyc != 2) begin failures++; $display("FAIL empty_done_cycle got=%0d want=2", done_cyc); end
  endtask

  task automatic test_backpressure();
    fill_rom_random();
    build_model(9);
    drive_run(8'd9, 2, 8);
    checks++; if (ce_hold != DEPTH) begin failures++; $display("FAIL bp_pushes_while_blocked got=%0d want=%0d", ce_hold, DEPTH); end
    checks++; if (beat_errors() != 0) begin failures++; $display("FAIL bp_beats bad=%0d want=0 n=%0d", beat_errors(), obs_idx.size()); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d want=0", stall_err); end
  endtask

  task automatic test_random_ready();
    fill_rom_random();
    build_model(31);
    drive_run(8'd31, 1, 0);
    checks++; if (beat_errors() != 0) begin failures++; $display("FAIL rnd_beats bad=%0d want=0 n=%0d", beat_errors(), obs_idx.size()); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL rnd_stall_stable got=%0d want=0", stall_err); end
    checks++; if (ce_cnt != 32) begin failures++; $display("FAIL rnd_fetch_count got=%0d want=32", ce_cnt); end
    checks++; if (ce_bad != 0) begin failures++; $display("FAIL rnd_addr_ff got=%0d want=0", ce_bad); end
`ifdef READ_D_MONOTONIC_CHECK_EN
    checks++; if (o_d_err !== exp_err) begin failures++; $display("FAIL rnd_d_err got=%b want=%b", o_d_err, exp_err); end
`endif
  endtask

  task automatic test_rst_mid();
    int beats = 0;
    int cyc = 0;
    int late_done = 0;
    fill_rom_random();
    i_last_idx = 8'd20; i_start = 1'b1; i_out_ready = 1'b1;
    while (beats < 2 && cyc < 50) begin
      @(negedge clk); cyc++; i_start = 1'b0; #1;
      if (o_out_valid && i_out_ready) beats++;
    end
    checks++; if (beats != 2) begin failures++; $display("FAIL rst_mid_beats got=%0d want=2", beats); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_idle got valid=%b busy=%b want 0/0", o_out_valid, o_busy);
    end
    checks++; if (o_rom_addr !== 8'hff) begin failures++; $display("FAIL rst_mid_addr got=%h want=ff", o_rom_addr); end
    for (int k = 0; k < 4; k++) begin
      if (o_done !== 1'b0) late_done++;
      @(negedge clk); #1;
    end
    checks++; if (late_done != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d want=0", late_done); end
    build_model(5);
    drive_run(8'd5, 0, 0);
    checks++; if (beat_errors() != 0) begin failures++; $display("FAIL rst_mid_rerun bad=%0d want=0", beat_errors()); end
    checks++; if (done_cyc != 9) begin failures++; $display("FAIL rst_mid_rerun_done got=%0d want=9", done_cyc); end
  endtask

`ifdef READ_D_MONOTONIC_CHECK_EN
  task automatic test_monotonic();
    rom_dv[2] = 8'd3; rom_dv[1] = 8'd2; rom_dv[0] = 8'd4;
    build_model(2);
    drive_run(8'd2, 0, 0);
    checks++; if (o_d_err !== 1'b1 || exp_err !== 1'b1) begin
      failures++; $display("FAIL mono_set got=%b want=1", o_d_err);
    end
    rom_dv[2] = 8'd9; rom_dv[1] = 8'd9; rom_dv[0] = 8'd1;
    drive_run(8'd2, 0, 0);
    checks++; if (o_d_err !== 1'b0) begin failures++; $display("FAIL mono_clear got=%b want=0", o_d_err); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom_rd[i] = '0;
      rom_dv[i] = '0;
    end
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_random_ready();
    test_rst_mid();
`ifdef READ_D_MONOTONIC_CHECK_EN
    test_monotonic();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
